// File: rtl/bsg_noc_link_vc_mux.sv
// bsg_noc_link_vc_mux: muxes num_vc_p ready_and client links onto one tagged
// physical link ({vc_id, payload}, vc_id in the MSBs) and demuxes inbound
// tagged flits back to the per-channel links. Each direction of each channel
// has its own els_p-deep FIFO with no bypass.
//
// Handshake semantics: a flit moves on a link in a cycle where the sender's v
// and the receiver's ready_and_rev are both high at the rising clock edge.
// ready_and_rev never depends on v. Once this block raises phys_link_o.v
// with some channel, that channel and its data hold until the handshake.
//
// Link bit layout (MSB..LSB): {v, data, ready_and_rev}.
module bsg_noc_link_vc_mux #(
  parameter int width_p  = 8,
  parameter int num_vc_p = 2,
  parameter int els_p    = 4,
  localparam int vc_id_width_lp = (num_vc_p > 1) ? $clog2(num_vc_p) : 1,
  localparam int link_width_lp  = width_p + 2,
  localparam int phys_width_lp  = width_p + vc_id_width_lp + 2
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_vc_p*link_width_lp-1:0]   vc_link_i,
  output logic [num_vc_p*link_width_lp-1:0]   vc_link_o,
  input  logic [phys_width_lp-1:0]            phys_link_i,
  output logic [phys_width_lp-1:0]            phys_link_o,
  output logic                                bad_vc_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  // Grant lock: OPEN re-arbitrates every cycle, LOCKED holds the offered channel.
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e               r_state, w_state_n;
  logic [vc_id_width_lp-1:0] r_grant, w_grant_n;
  logic [vc_id_width_lp-1:0] r_rr_ptr, w_rr_ptr_n;
  logic                      r_bad;

  logic [num_vc_p-1:0] w_cl_v, w_cl_rdy;
  logic [width_p-1:0]  w_cl_data [num_vc_p];
  logic [num_vc_p-1:0] w_out_full, w_out_empty, w_out_ready;
  logic [num_vc_p-1:0] w_in_full, w_in_empty;
  logic [width_p-1:0]  w_out_head [num_vc_p];
  logic [width_p-1:0]  w_in_head  [num_vc_p];

  logic                      w_tx_v, w_tx_rdy, w_tx_hs;
  logic                      w_rx_v, w_rx_rdy, w_rx_hs, w_rx_bad;
  logic [vc_id_width_lp-1:0] w_rx_id;
  logic [width_p-1:0]        w_rx_data;
  logic [vc_id_width_lp-1:0] w_rr_pick, w_grant;
  int                        w_best, w_dist;

  // Physical link fields.
  assign w_tx_rdy  = phys_link_i[0];
  assign w_rx_v    = phys_link_i[phys_width_lp-1];
  assign w_rx_id   = phys_link_i[width_p+1 +: vc_id_width_lp];
  assign w_rx_data = phys_link_i[1 +: width_p];

  // Inbound readiness is conservative: any full inbound FIFO stalls the link.
  assign w_rx_rdy = reset_n_i & ~(|w_in_full);
  assign w_rx_hs  = w_rx_v & w_rx_rdy;
  assign w_rx_bad = w_rx_hs & (int'(w_rx_id) >= num_vc_p);

  assign w_tx_v  = ~(&w_out_empty);
  assign w_tx_hs = w_tx_v & w_tx_rdy;
  assign w_grant = (r_state == ST_LOCKED) ? r_grant : w_rr_pick;

  assign phys_link_o = {w_tx_v, w_grant, w_out_head[w_grant], w_rx_rdy};
  assign bad_vc_o    = r_bad;

  for (genvar i = 0; i < num_vc_p; i++) begin : g_vc
    logic [width_p-1:0]  r_out_mem [els_p];
    logic [width_p-1:0]  r_in_mem  [els_p];
    logic [ptr_w_lp:0]   r_out_wptr, r_out_rptr, r_in_wptr, r_in_rptr;
    logic                w_out_enq, w_out_deq, w_in_enq, w_in_deq;

    assign w_cl_v[i]    = vc_link_i[i*link_width_lp + link_width_lp - 1];
    assign w_cl_data[i] = vc_link_i[i*link_width_lp + 1 +: width_p];
    assign w_cl_rdy[i]  = vc_link_i[i*link_width_lp];

    assign w_out_empty[i] = (r_out_wptr == r_out_rptr);
    assign w_out_full[i]  = (r_out_wptr[ptr_w_lp] != r_out_rptr[ptr_w_lp]) &&
                            (r_out_wptr[ptr_w_lp-1:0] == r_out_rptr[ptr_w_lp-1:0]);
    assign w_out_ready[i] = reset_n_i & ~w_out_full[i];
    assign w_out_enq      = w_cl_v[i] & w_out_ready[i];
    assign w_out_deq      = w_tx_hs & (int'(w_grant) == i);
    assign w_out_head[i]  = r_out_mem[r_out_rptr[ptr_w_lp-1:0]];

    assign w_in_empty[i] = (r_in_wptr == r_in_rptr);
    assign w_in_full[i]  = (r_in_wptr[ptr_w_lp] != r_in_rptr[ptr_w_lp]) &&
                           (r_in_wptr[ptr_w_lp-1:0] == r_in_rptr[ptr_w_lp-1:0]);
    assign w_in_enq      = w_rx_hs & (int'(w_rx_id) == i);
    assign w_in_deq      = ~w_in_empty[i] & w_cl_rdy[i];
    assign w_in_head[i]  = r_in_mem[r_in_rptr[ptr_w_lp-1:0]];

    assign vc_link_o[i*link_width_lp +: link_width_lp] =
      {~w_in_empty[i], w_in_head[i], w_out_ready[i]};

    // FIFO pointers for both directions; extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_out_wptr <= '0;
        r_out_rptr <= '0;
        r_in_wptr  <= '0;
        r_in_rptr  <= '0;
      end else begin
        if (w_out_enq) r_out_wptr <= r_out_wptr + 1'b1;
        if (w_out_deq) r_out_rptr <= r_out_rptr + 1'b1;
        if (w_in_enq)  r_in_wptr  <= r_in_wptr + 1'b1;
        if (w_in_deq)  r_in_rptr  <= r_in_rptr + 1'b1;
      end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
      if (w_out_enq) r_out_mem[r_out_wptr[ptr_w_lp-1:0]] <= w_cl_data[i];
      if (w_in_enq)  r_in_mem[r_in_wptr[ptr_w_lp-1:0]]   <= w_rx_data;
    end
  end

  // Round-robin pick: non-empty channel closest at or after the pointer.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    w_best    = num_vc_p;
    w_dist    = 0;
    for (int j = 0; j < num_vc_p; j++) begin
      w_dist = (j >= int'(r_rr_ptr)) ? (j - int'(r_rr_ptr))
                                     : (j + num_vc_p - int'(r_rr_ptr));
      if (!w_out_empty[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_rr_pick = j[vc_id_width_lp-1:0];
      end
    end
  end

  // Lock next-state and pointer advance on an outbound handshake.
  always_comb begin
    w_state_n  = r_state;
    w_grant_n  = r_grant;
    w_rr_ptr_n = r_rr_ptr;
    case (r_state)
      ST_OPEN: begin
        if (w_tx_v && !w_tx_rdy) begin
          w_state_n = ST_LOCKED;
          w_grant_n = w_rr_pick;
        end
      end
      ST_LOCKED: begin
        if (w_tx_rdy) w_state_n = ST_OPEN;
      end
    endcase
    if (w_tx_hs) begin
      w_rr_ptr_n = (int'(w_grant) == num_vc_p - 1) ? '0 : (w_grant + 1'b1);
    end
  end

  // Arbitration state and the sticky bad-id flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_OPEN;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_rr_ptr <= w_rr_ptr_n;
      r_bad    <= r_bad | w_rx_bad;
    end
  end

endmodule

// File: tb/tb_bsg_noc_link_vc_mux.sv
// Bench for bsg_noc_link_vc_mux with three channels so that an out-of-range
// tag (id 3) can be injected. Stimulus is applied just after each rising edge;
// a monitor on the falling edge compares every output against a queue-based
// model of the link and then advances that model by the handshakes that the
// coming rising edge will complete.
module tb_bsg_noc_link_vc_mux;

  localparam int NVC = 3;
  localparam int W   = 8;
  localparam int ELS = 4;
  localparam int IDW = 2;
  localparam int L   = W + 2;
  localparam int PW  = W + IDW;
  localparam int PL  = PW + 2;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_n_i = 1'b1;
  always #5 clk = ~clk;

  // Driven inputs
  logic [NVC-1:0] cv = '0, cr = '0;
  logic [W-1:0]   cd [NVC];
  logic           pv = 1'b0, pr = 1'b0;
  logic [IDW-1:0] pid = '0;
  logic [W-1:0]   pd = '0;

  logic [NVC*L-1:0] vc_link_i, vc_link_o;
  logic [PL-1:0]    phys_link_i, phys_link_o;
  logic             bad_vc_o;

  always_comb begin
    vc_link_i = '0;
    for (int i = 0; i < NVC; i++) vc_link_i[i*L +: L] = {cv[i], cd[i], cr[i]};
  end
  assign phys_link_i = {pv, pid, pd, pr};

  // Decoded outputs
  logic [NVC-1:0] vo_v, vo_rdy;
  logic [W-1:0]   vo_d [NVC];
  for (genvar i = 0; i < NVC; i++) begin : g_unpack
    assign vo_v[i]   = vc_link_o[i*L + L - 1];
    assign vo_d[i]   = vc_link_o[i*L + 1 +: W];
    assign vo_rdy[i] = vc_link_o[i*L];
  end
  logic          po_v, po_rdy;
  logic [PW-1:0] po_d;
  assign po_v   = phys_link_o[PL-1];
  assign po_d   = phys_link_o[1 +: PW];
  assign po_rdy = phys_link_o[0];

  bsg_noc_link_vc_mux #(.width_p(W), .num_vc_p(NVC), .els_p(ELS)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .vc_link_i   (vc_link_i),
    .vc_link_o   (vc_link_o),
    .phys_link_i (phys_link_i),
    .phys_link_o (phys_link_o),
    .bad_vc_o    (bad_vc_o)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [W-1:0] out_q [NVC][$];
  logic [W-1:0] in_q  [NVC][$];
  int rr_ptr, lk_id;
  bit lk, bad_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < NVC; i++) begin
      chk($sformatf("%s_vc%0d_v", tag, i), 32'(vo_v[i]), 32'd0);
      chk($sformatf("%s_vc%0d_rdy", tag, i), 32'(vo_rdy[i]), 32'd0);
    end
    chk({tag, "_phys_v"}, 32'(po_v), 32'd0);
    chk({tag, "_phys_rdy"}, 32'(po_rdy), 32'd0);
    chk({tag, "_bad"}, 32'(bad_vc_o), 32'd0);
  endtask

  // Driver: one cycle of inputs, fresh random payloads
  task automatic drive(input logic [NVC-1:0] v, input logic [NVC-1:0] rdy,
                       input logic p_rdy, input logic p_v, input int p_id);
    @(posedge clk);
    #1;
    cv  = v;
    cr  = rdy;
    pr  = p_rdy;
    pv  = p_v;
    pid = IDW'(p_id);
    for (int i = 0; i < NVC; i++) cd[i] = W'($urandom_range(0, 255));
    pd = W'($urandom_range(0, 255));
  endtask

  task automatic rand_cycle(input int pr_pct, input bit cr_heavy);
    logic [NVC-1:0] rdy;
    rdy = NVC'($urandom_range(0, 7));
    if (cr_heavy) rdy = rdy | NVC'($urandom_range(0, 7));
    drive(NVC'($urandom_range(0, 7)), rdy, ($urandom_range(0, 99) < pr_pct),
          1'($urandom_range(0, 1)), $urandom_range(0, NVC - 1));
  endtask

  // Monitor: compare against the model, then apply this cycle's handshakes
  initial begin : monitor
    int g;
    bit any_v, e_rx_rdy;
    logic [NVC-1:0] e_tx_rdy;
    logic [PW-1:0] e_pd;
    rr_ptr = 0; lk = 0; lk_id = 0; bad_m = 0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        for (int i = 0; i < NVC; i++) begin
          out_q[i].delete();
          in_q[i].delete();
        end
        rr_ptr = 0; lk = 0; lk_id = 0; bad_m = 0;
      end else begin
        e_rx_rdy = 1'b1;
        any_v = 1'b0;
        for (int i = 0; i < NVC; i++) begin
          if (in_q[i].size() >= ELS) e_rx_rdy = 1'b0;
          if (out_q[i].size() > 0) any_v = 1'b1;
          e_tx_rdy[i] = (out_q[i].size() < ELS);
        end
        g = -1;
        if (any_v) begin
          if (lk) g = lk_id;
          else
            for (int k = 0; k < NVC; k++)
              if (g < 0 && out_q[(rr_ptr + k) % NVC].size() > 0) g = (rr_ptr + k) % NVC;
        end
        for (int i = 0; i < NVC; i++) begin
          chk($sformatf("vc%0d_out_rdy", i), 32'(vo_rdy[i]), 32'(e_tx_rdy[i]));
          chk($sformatf("vc%0d_in_v", i), 32'(vo_v[i]), 32'(in_q[i].size() > 0));
          if (in_q[i].size() > 0)
            chk($sformatf("vc%0d_in_data", i), 32'(vo_d[i]), 32'(in_q[i][0]));
        end
        chk("phys_in_rdy", 32'(po_rdy), 32'(e_rx_rdy));
        chk("phys_out_v", 32'(po_v), 32'(any_v));
        if (any_v) begin
          e_pd = {IDW'(g), out_q[g][0]};
          chk("phys_out_data", 32'(po_d), 32'(e_pd));
        end
        chk("bad_vc", 32'(bad_vc_o), 32'(bad_m));

        if (any_v) begin
          if (pr) begin
            void'(out_q[g].pop_front());
            rr_ptr = (g + 1) % NVC;
            lk = 0;
          end else begin
            lk = 1;
            lk_id = g;
          end
        end
        for (int i = 0; i < NVC; i++) begin
          if (cv[i] && e_tx_rdy[i]) out_q[i].push_back(cd[i]);
          if (in_q[i].size() > 0 && cr[i]) void'(in_q[i].pop_front());
        end
        if (pv && e_rx_rdy) begin
          if (int'(pid) < NVC) in_q[int'(pid)].push_back(pd);
          else bad_m = 1;
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < NVC; i++) cd[i] = '0;
    #2 reset_n_i = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;

    // Single flit on channel 1
    drive(3'b010, 3'b111, 1'b1, 1'b0, 0);
    cd[1] = 8'hA5;
    repeat (3) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // All channels saturated, link always ready
    repeat (24) drive(3'b111, 3'b111, 1'b1, 1'b0, 0);
    repeat (12) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Grant lock: channel 0 waits, channel 1 arrives while locked
    drive(3'b001, 3'b111, 1'b0, 1'b0, 0);
    drive(3'b000, 3'b111, 1'b0, 1'b0, 0);
    drive(3'b010, 3'b111, 1'b0, 1'b0, 0);
    repeat (3) drive(3'b000, 3'b111, 1'b0, 1'b0, 0);
    repeat (4) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Outbound backpressure on channel 0
    repeat (6) drive(3'b001, 3'b111, 1'b0, 1'b0, 0);
    repeat (2) drive(3'b000, 3'b111, 1'b0, 1'b0, 0);
    repeat (8) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Inbound demux with channel 1 client stalled
    drive(3'b000, 3'b101, 1'b1, 1'b1, 0); pd = 8'h11;
    drive(3'b000, 3'b101, 1'b1, 1'b1, 1); pd = 8'h22;
    drive(3'b000, 3'b101, 1'b1, 1'b1, 1); pd = 8'h33;
    repeat (5) drive(3'b000, 3'b101, 1'b1, 1'b1, 1);
    repeat (10) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Random traffic with varying link and client readiness
    repeat (1000) rand_cycle(95, 1'b1);
    repeat (1000) rand_cycle(50, 1'b0);
    repeat (1000) rand_cycle(20, 1'b1);
    repeat (20) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Out-of-range tag
    drive(3'b000, 3'b111, 1'b1, 1'b1, 3);
    repeat (3) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    // Reset in the middle of traffic
    repeat (20) rand_cycle(60, 1'b0);
    @(posedge clk);
    #3;
    reset_n_i = 1'b0;
    cv = '0; cr = '0; pv = 1'b0; pr = 1'b0;
    #1 chk_reset_outputs("mid");
    @(posedge clk);
    #1 reset_n_i = 1'b1;
    repeat (200) rand_cycle(70, 1'b1);
    repeat (20) drive(3'b000, 3'b111, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
